// File: rtl/miscv_pkg.sv
// Shared types and constants for the 16-bit MiSC-V pipeline front end.
package miscv_pkg;

    localparam int XLEN = 16;

    // Instruction word used for pipeline bubbles and squashed slots.
    localparam logic [XLEN-1:0] NOP_INSTR = 16'h0000;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // one quiet cycle after reset
        S_REQ  = 2'd1,  // issuing / waiting on a live request
        S_DROP = 2'd2   // waiting on a squashed request whose data is discarded
    } fetch_state_t;

    // One buffered fetch result.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
    } fetch_entry_t;

    // Sequential instruction address (instructions are 2 bytes, wraps at 2^16).
    function automatic logic [XLEN-1:0] pc_plus2(input logic [XLEN-1:0] pc);
        return pc + XLEN'(2);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO holding returned fetch words until decode accepts them.
// Flush outranks push, so a word returning in a redirect cycle never lands.
module fetch_fifo
    import miscv_pkg::*;
(
    input  logic         CLK,
    input  logic         Reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO.
    // NOTE: registers use <= so every flop in this block samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (Reset || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage written on accepted pushes.
    // NOTE: the data array is deliberately not reset; count alone decides which entries are valid.
    always_ff @(posedge CLK) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the MiSC-V pipeline: owns the PC, keeps at most
// one instruction-memory request outstanding, buffers returned words in a
// two-entry FIFO and presents them to the IF/ID register.
// Optional feature macro: FETCH_STALLCNT_EN adds the stall_cycles counter port.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = miscv_pkg::NOP_INSTR
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        if_write,
    output logic [15:0] if_pc,
    output logic [15:0] if_pcp2,
    output logic [15:0] if_ir
`ifdef FETCH_STALLCNT_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    import miscv_pkg::*;

    fetch_state_t state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  drop_addr_q, drop_addr_d;
    logic         pending_q, pending_d;

    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_flush;
    logic [1:0]   fifo_count;
    fetch_entry_t fifo_head;
    fetch_entry_t fifo_in;
    logic         fifo_empty;

    // Bit 0 of the redirect target is forced to zero, so it is intentionally unused.
    logic         unused_redirect_bit0;
    assign unused_redirect_bit0 = redirect_pc[0];

    assign fifo_empty = (fifo_count == 2'd0);
    assign fifo_in    = '{pc: pc_q, ir: imem_rdata};

    fetch_fifo u_fifo (
        .CLK       (CLK),
        .Reset     (Reset),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // Sequencer state, PC and outstanding-request bookkeeping.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            pending_q   <= pending_d;
        end
    end

    // Next-state logic, memory handshake and IF/ID presentation.
    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        pending_d   = pending_q;
        imem_req    = 1'b0;
        imem_addr   = pc_q;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;
        if_write    = 1'b0;
        if_pc       = 16'h0000;
        if_pcp2     = 16'h0000;
        if_ir       = NOP_INSTR;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                // A raised request is held; a new one starts only with room to land
                // and never in a redirect cycle (its address would be wrong-path).
                imem_req  = pending_q || (!redirect && (fifo_count <= 2'd1));
                pending_d = imem_req && !imem_ack;
                if (redirect) begin
                    if (pending_d) begin
                        state_d     = S_DROP;
                        drop_addr_d = pc_q;
                        pending_d   = 1'b0;
                    end
                end else if (imem_req && imem_ack) begin
                    fifo_push = 1'b1;
                    pc_d      = pc_plus2(pc_q);
                end
            end
            S_DROP: begin
                // Squashed request stays on the bus at its original address.
                imem_req  = 1'b1;
                imem_addr = drop_addr_q;
                if (imem_ack) state_d = S_REQ;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (redirect) begin
            fifo_flush = 1'b1;
            pc_d       = {redirect_pc[15:1], 1'b0};
        end

        // Redirect slot and empty FIFO both present a bubble.
        if_write = redirect || !stall;
        if (!redirect && !fifo_empty) begin
            if_pc   = fifo_head.pc;
            if_pcp2 = pc_plus2(fifo_head.pc);
            if_ir   = fifo_head.ir;
        end
        fifo_pop = !redirect && !stall && !fifo_empty;

        // Reset silences the bus and the IF/ID strobe; a late ack is ignored.
        if (Reset) begin
            imem_req = 1'b0;
            if_write = 1'b0;
            if_pc    = 16'h0000;
            if_pcp2  = 16'h0000;
            if_ir    = NOP_INSTR;
        end
    end

`ifdef FETCH_STALLCNT_EN
    // Saturating count of cycles in which decode held IF/ID.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            stall_cycles <= 16'h0000;
        end else if (stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule
